// File: rtl/ps2_kbd_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_kbd_ctrl
//
// Purpose:
//   Turns a stream of raw PS/2 keyboard scancode bytes into key events.
//   A small decoder FSM handles the E0 (extended) and F0 (break) prefixes,
//   swallows the eight-byte E1 Pause sequence as a single event, filters
//   acknowledge/echo bytes, and flags self-test pass (0xAA) and error bytes.
//   Decoded events {code, ext, break} are queued in a FIFO for the consumer.
//
// Ports:
//   clkin      in   sole clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   sym_data   in   [7:0] scancode byte from the PS/2 physical layer
//   sym_valid  in   sym_data is valid
//   sym_ready  out  byte accepted when sym_valid && sym_ready (low only when full)
//   evt_code   out  [7:0] key code of the head event
//   evt_ext    out  head event carried the E0 prefix
//   evt_break  out  head event is a key release
//   evt_valid  out  FIFO holds at least one event
//   evt_ready  in   consumer pops the head when evt_valid && evt_ready
//   evt_count  out  [clog2(FIFO_DEPTH):0] FIFO occupancy
//   bat_ok     out  one-cycle pulse after an accepted 0xAA byte
//   err        out  one-cycle pulse after an error byte or a prefix timeout
// ---------------------------------------------------------------------------
module ps2_kbd_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [23:0] TIMEOUT    = 24'd1000000
) (
    input  logic                          clkin,
    input  logic                          rst,
    input  logic [7:0]                    sym_data,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          bat_ok,
    output logic                          err
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [23:0] TMO_LAST = TIMEOUT - 24'd1;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK,
        SKIP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  skip_cnt;
    logic [2:0]  skip_next;
    logic [23:0] tmo_cnt;
    logic [23:0] tmo_next;
    logic        err_next;
    logic        bat_next;

    logic        push;
    logic        push_ext;
    logic        push_brk;
    logic [7:0]  push_code;
    logic        pop;
    logic        accept;
    logic        full;
    logic        err_byte;

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Handshake: back-pressure only when the FIFO is full, so every accepted
    // byte is guaranteed room for the event it might produce.
    assign full      = (evt_count == CW'(FIFO_DEPTH));
    assign sym_ready = !full;
    assign accept    = sym_valid && sym_ready;
    assign evt_valid = (evt_count != '0);
    assign pop       = evt_valid && evt_ready;
    assign err_byte  = (sym_data == 8'h00) || (sym_data == 8'hFF) || (sym_data == 8'hFC);

    assign {evt_code, evt_ext, evt_break} = mem[rd_ptr];

    // Decoder next-state logic. An accepted byte always takes priority over
    // the prefix timeout; the timeout only matters while waiting in a
    // non-IDLE state with no byte arriving.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        push       = 1'b0;
        push_code  = sym_data;
        push_ext   = 1'b0;
        push_brk   = 1'b0;
        err_next   = 1'b0;
        bat_next   = 1'b0;
        tmo_next   = tmo_cnt;

        if (accept) begin
            case (state)
                IDLE: begin
                    if (sym_data == 8'hE0) begin
                        state_next = EXT;
                    end else if (sym_data == 8'hF0) begin
                        state_next = BRK;
                    end else if (sym_data == 8'hE1) begin
                        state_next = SKIP;
                        skip_next  = 3'd7;
                    end else if (sym_data == 8'hAA) begin
                        bat_next = 1'b1;
                    end else if (err_byte) begin
                        err_next = 1'b1;
                    end else if ((sym_data == 8'hFA) || (sym_data == 8'hEE)) begin
                        push = 1'b0;
                    end else begin
                        push = 1'b1;
                    end
                end
                EXT: begin
                    if (err_byte) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (sym_data == 8'hF0) begin
                        state_next = EXTBRK;
                    end else if (sym_data != 8'hE0) begin
                        push       = 1'b1;
                        push_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    if (err_byte) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (sym_data == 8'hE0) begin
                        state_next = EXTBRK;
                    end else begin
                        push       = 1'b1;
                        push_brk   = 1'b1;
                        state_next = IDLE;
                    end
                end
                EXTBRK: begin
                    if (err_byte) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if ((sym_data != 8'hE0) && (sym_data != 8'hF0)) begin
                        push       = 1'b1;
                        push_ext   = 1'b1;
                        push_brk   = 1'b1;
                        state_next = IDLE;
                    end
                end
                SKIP: begin
                    // The Pause key sends E1 followed by seven more bytes; the
                    // last of them stands in for the whole sequence.
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        push       = 1'b1;
                        push_code  = 8'hE1;
                        skip_next  = 3'd0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if ((state != IDLE) && (tmo_cnt == TMO_LAST)) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end

        if (accept || (state_next == IDLE)) begin
            tmo_next = 24'd0;
        end else begin
            tmo_next = tmo_cnt + 24'd1;
        end
    end

    // Decoder state, counters and the registered status pulses.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
            tmo_cnt  <= 24'd0;
            err      <= 1'b0;
            bat_ok   <= 1'b0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            tmo_cnt  <= tmo_next;
            err      <= err_next;
            bat_ok   <= bat_next;
        end
    end

    // Event storage. Entries need no reset: evt_count gates their visibility.
    always_ff @(posedge clkin) begin
        if (push) begin
            mem[wr_ptr] <= {push_code, push_ext, push_brk};
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two; a push can never hit a full FIFO since bytes are
    // only accepted when there is room.
    always_ff @(posedge clkin) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   evt_count <= evt_count + CW'(1);
                2'b01:   evt_count <= evt_count - CW'(1);
                default: evt_count <= evt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_ctrl
//
// Purpose:
//   Directed self-checking bench for ps2_kbd_ctrl. Feeds hand-picked scancode
//   sequences and compares events, occupancy and status pulses against
//   hand-computed values. A short TIMEOUT keeps the prefix-timeout case fast.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_ctrl;

    localparam int          DEPTH = 8;
    localparam logic [23:0] TMO   = 24'd40;

    logic       clkin = 1'b0;
    logic       rst;
    logic [7:0] sym_data;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_count;
    logic       bat_ok;
    logic       err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] fill_codes [0:8];

    ps2_kbd_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_count (evt_count),
        .bat_ok    (bat_ok),
        .err       (err)
    );

    // Free-running 10 ns clock.
    always #5 clkin = ~clkin;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents one byte and holds it until accepted (bounded wait). Called at
    // a falling edge; returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        sym_data  = b;
        sym_valid = 1'b1;
        waited    = 0;
        while (!sym_ready && waited < 200) begin
            @(negedge clkin);
            waited++;
        end
        if (!sym_ready) begin
            checkOutput("accept_wait", 32'd0, 32'd1);
            sym_valid = 1'b0;
        end else begin
            @(posedge clkin);
            #1;
            sym_valid = 1'b0;
            @(negedge clkin);
        end
    endtask

    // Checks the head event against the expected {code, ext, brk}.
    task automatic checkEvent(input string tag, input logic [7:0] code,
                              input logic ext, input logic brk);
        checkOutput({tag, "_valid"}, 32'(evt_valid), 32'd1);
        checkOutput({tag, "_evt"}, 32'({evt_code, evt_ext, evt_break}),
                    32'({code, ext, brk}));
    endtask

    // Pops the head event with a single-cycle evt_ready strobe.
    task automatic popEvent();
        evt_ready = 1'b1;
        @(posedge clkin);
        #1;
        evt_ready = 1'b0;
        @(negedge clkin);
    endtask

    initial begin
        int first_err;
        int err_pulses;

        fill_codes[0] = 8'h15; fill_codes[1] = 8'h1D; fill_codes[2] = 8'h24;
        fill_codes[3] = 8'h2D; fill_codes[4] = 8'h2C; fill_codes[5] = 8'h35;
        fill_codes[6] = 8'h3C; fill_codes[7] = 8'h43; fill_codes[8] = 8'h44;

        rst       = 1'b1;
        sym_data  = 8'h00;
        sym_valid = 1'b0;
        evt_ready = 1'b0;
        repeat (3) @(posedge clkin);
        @(negedge clkin);
        checkOutput("rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_count", 32'(evt_count), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_bat", 32'(bat_ok), 32'd0);
        rst = 1'b0;
        @(negedge clkin);
        checkOutput("rst_ready", 32'(sym_ready), 32'd1);

        // Make then break of the same key with the consumer always ready.
        $display("[TB] make/break with evt_ready=1");
        evt_ready = 1'b1;
        applyStimulus(8'h1C);
        checkEvent("make_1c", 8'h1C, 1'b0, 1'b0);
        applyStimulus(8'hF0);
        checkOutput("after_f0_valid", 32'(evt_valid), 32'd0);
        applyStimulus(8'h1C);
        checkEvent("break_1c", 8'h1C, 1'b0, 1'b1);
        @(negedge clkin);
        checkOutput("drain_count", 32'(evt_count), 32'd0);
        evt_ready = 1'b0;

        // Extended break and the Pause sequence.
        $display("[TB] prefix sequences");
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        checkOutput("extbrk_count", 32'(evt_count), 32'd1);
        checkEvent("extbrk_75", 8'h75, 1'b1, 1'b1);
        popEvent();
        checkOutput("extbrk_pop", 32'(evt_count), 32'd0);

        applyStimulus(8'hE1);
        applyStimulus(8'h14);
        applyStimulus(8'h77);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        applyStimulus(8'h14);
        applyStimulus(8'hF0);
        checkOutput("pause_mid_count", 32'(evt_count), 32'd0);
        applyStimulus(8'h77);
        checkOutput("pause_count", 32'(evt_count), 32'd1);
        checkEvent("pause_evt", 8'hE1, 1'b0, 1'b0);
        popEvent();

        applyStimulus(8'hE0);
        applyStimulus(8'hE0);
        applyStimulus(8'h12);
        checkEvent("ext_e0e0", 8'h12, 1'b1, 1'b0);
        popEvent();

        applyStimulus(8'hF0);
        applyStimulus(8'hE0);
        applyStimulus(8'h74);
        checkEvent("brk_e0", 8'h74, 1'b1, 1'b1);
        popEvent();

        // Filtered and error bytes.
        $display("[TB] filtered and error bytes");
        applyStimulus(8'hFA);
        applyStimulus(8'hEE);
        checkOutput("ack_echo_count", 32'(evt_count), 32'd0);
        applyStimulus(8'hFF);
        checkOutput("err_ff", 32'(err), 32'd1);
        @(negedge clkin);
        checkOutput("err_ff_clear", 32'(err), 32'd0);
        applyStimulus(8'hF0);
        applyStimulus(8'hFC);
        checkOutput("err_brk_fc", 32'(err), 32'd1);
        checkOutput("err_brk_count", 32'(evt_count), 32'd0);
        applyStimulus(8'h1C);
        checkEvent("after_err_idle", 8'h1C, 1'b0, 1'b0);
        popEvent();

        // Fill the FIFO, hold a ninth byte, then drain in order.
        $display("[TB] FIFO full / back-pressure");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(fill_codes[i]);
        end
        checkOutput("full_count", 32'(evt_count), 32'd8);
        checkOutput("full_ready", 32'(sym_ready), 32'd0);
        sym_data  = fill_codes[8];
        sym_valid = 1'b1;
        repeat (3) @(negedge clkin);
        checkOutput("held_count", 32'(evt_count), 32'd8);
        checkOutput("held_ready", 32'(sym_ready), 32'd0);
        checkEvent("held_head", fill_codes[0], 1'b0, 1'b0);
        evt_ready = 1'b1;
        @(posedge clkin);
        #1;
        evt_ready = 1'b0;
        @(negedge clkin);
        checkOutput("pop_one_count", 32'(evt_count), 32'd7);
        checkOutput("pop_one_ready", 32'(sym_ready), 32'd1);
        @(posedge clkin);
        #1;
        sym_valid = 1'b0;
        @(negedge clkin);
        checkOutput("ninth_count", 32'(evt_count), 32'd8);
        for (int i = 1; i < 9; i++) begin
            checkEvent($sformatf("order_%0d", i), fill_codes[i], 1'b0, 1'b0);
            popEvent();
        end
        checkOutput("order_empty", 32'(evt_count), 32'd0);

        // Prefix timeout: E0 then silence.
        $display("[TB] prefix timeout");
        applyStimulus(8'hE0);
        first_err  = -1;
        err_pulses = 0;
        for (int j = 1; j <= int'(TMO) + 10; j++) begin
            @(negedge clkin);
            if (err) begin
                err_pulses++;
                if (first_err < 0) first_err = j;
            end
        end
        checkOutput("tmo_pulses", 32'(err_pulses), 32'd1);
        checkOutput("tmo_window", 32'((first_err >= int'(TMO) - 1) && (first_err <= int'(TMO) + 1)), 32'd1);
        checkOutput("tmo_no_push", 32'(evt_count), 32'd0);
        applyStimulus(8'h75);
        checkEvent("tmo_then_75", 8'h75, 1'b0, 1'b0);
        popEvent();
        applyStimulus(8'hAA);
        checkOutput("bat_pulse", 32'(bat_ok), 32'd1);
        checkOutput("bat_no_evt", 32'(evt_count), 32'd0);
        @(negedge clkin);
        checkOutput("bat_clear", 32'(bat_ok), 32'd0);

        // Reset in the middle of a break prefix with events queued.
        $display("[TB] mid-sequence reset");
        applyStimulus(8'h15);
        applyStimulus(8'h1D);
        applyStimulus(8'h24);
        applyStimulus(8'hF0);
        checkOutput("pre_rst_count", 32'(evt_count), 32'd3);
        rst = 1'b1;
        @(posedge clkin);
        #1;
        rst = 1'b0;
        @(negedge clkin);
        checkOutput("mid_rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("mid_rst_count", 32'(evt_count), 32'd0);
        checkOutput("mid_rst_ready", 32'(sym_ready), 32'd1);
        applyStimulus(8'h1C);
        checkEvent("post_rst_1c", 8'h1C, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT, default 24'd1000000, clkin cycles a prefix state may wait for its next byte.
REQ-003 clkin  in  1  sole clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sym_data  in  8  scancode byte from PS/2 physical interface.
REQ-006 sym_valid  in  1  sym_data valid.
REQ-007 sym_ready  out  1  byte accepted on cycles where sym_valid && sym_ready.
REQ-008 evt_code  out  8  key code of head event.
REQ-009 evt_ext  out  1  head event carried E0 prefix.
REQ-010 evt_break  out  1  head event is key release.
REQ-011 evt_valid  out  1  FIFO non-empty; head event presented.
REQ-012 evt_ready  in  1  consumer pops head when evt_valid && evt_ready.
REQ-013 evt_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 bat_ok  out  1  one-cycle pulse on accepted byte 0xAA.
REQ-015 err  out  1  one-cycle pulse on error byte (0x00, 0xFF, 0xFC) or prefix timeout.

Function
REQ-016 sym_ready SHALL equal !full, registered-free (combinational from occupancy); no byte is ever dropped for lack of space.
REQ-017 Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen), SKIP (E1 pause sequence).
REQ-018 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; 0xE1 -> SKIP with skip counter = 7; 0xAA -> pulse bat_ok, stay; 0x00/0xFF/0xFC -> pulse err, stay; 0xFA/0xEE -> discard, stay; any other byte -> push {code, ext=0, brk=0}, stay.
REQ-019 EXT: 0xF0 -> EXTBRK; 0xE0 -> stay EXT; other -> push {code, ext=1, brk=0}, IDLE.
REQ-020 BRK: 0xE0 -> EXTBRK; other -> push {code, ext=0, brk=1}, IDLE.
REQ-021 EXTBRK: any byte except 0xE0/0xF0 -> push {code, ext=1, brk=1}, IDLE; 0xE0/0xF0 -> stay.
REQ-022 In EXT/BRK/EXTBRK, error bytes 0x00/0xFF/0xFC SHALL pulse err and return to IDLE without push.
REQ-023 SKIP: each accepted byte decrements skip counter; byte accepted at count 1 pushes {0xE1, ext=0, brk=0} and returns to IDLE; no other effect of bytes in SKIP.
REQ-024 Timeout counter SHALL clear on every accepted byte and on entry to IDLE, increment each cycle in non-IDLE states; on reaching TIMEOUT, FSM -> IDLE, err pulses, no push.
REQ-025 Timeout and byte acceptance in same cycle: byte wins, no err.
REQ-026 Push latency: event pushed on accepted-byte cycle N SHALL be visible at head (evt_valid=1 if it is the only entry) at cycle N+1.
REQ-027 FIFO SHALL be first-in first-out; evt_* outputs stable while evt_valid && !evt_ready.
REQ-028 Simultaneous push and pop SHALL keep evt_count unchanged; pop when empty and push when full SHALL not occur (gated internally).
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; full = (evt_count == FIFO_DEPTH).
REQ-030 bat_ok and err SHALL be single-cycle, registered, asserted cycle N+1 after causing event at cycle N.

Reset
REQ-031 While rst=1 at clkin edge: FSM=IDLE, skip and timeout counters=0, FIFO pointers and evt_count=0, evt_valid=0, bat_ok=0, err=0.
REQ-032 sym_ready SHALL read 1 the cycle after reset deasserts; reset mid-sequence discards partial prefix and all queued events.
REQ-033 evt_code/evt_ext/evt_break are don't-care while evt_valid=0.

Verification
REQ-034 Bytes 0x1C, 0xF0, 0x1C with evt_ready=1 -> events {1C,0,0} then {1C,0,1}; evt_count returns to 0.
REQ-035 Bytes 0xE0, 0xF0, 0x75 -> single event {75,1,1}; E1 14 77 E1 F0 14 F0 77 -> single event {E1,0,0}.
REQ-036 evt_ready=0, push 8 make codes -> evt_count=8, sym_ready=0; 9th byte held; pop one -> sym_ready=1 next cycle, 9th accepted, order preserved.
REQ-037 Byte 0xE0 then idle TIMEOUT cycles -> err pulse, FSM IDLE; following 0x75 -> {75,0,0}; 0xAA -> bat_ok pulse, no event.
REQ-038 Assert rst after 0xF0 with 3 events queued -> evt_valid=0, evt_count=0; next 0x1C -> {1C,0,0}.
